dm_mem_responder: RTL and testbench

//  Memory-side responder for the pipelined CPU's data-memory port (addr/re/we/wrt_data -> rd_data).

---
 rtl/dm_mem_responder_pkg.sv | 15 +
 rtl/dm_mem_array.sv | 44 ++++
 rtl/dm_mem_responder.sv | 114 +++++++++++
 tb/tb_dm_mem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dm_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and widths
// that the CPU top level also uses.
package dm_mem_responder_pkg;

  localparam int DM_DATA_W          = 16;
  localparam int DM_DEFAULT_LATENCY = 4;
  localparam int DM_CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dm_state_e;

endpackage

// File: rtl/dm_mem_array.sv
// Backing storage for the responder: synchronous write, registered read port.
// The read register doubles as the responder's rd_data and holds between reads.
module dm_mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // A simultaneous read and write returns the data being written.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = we ? wdata : mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_mem_responder.sv
// Multi-cycle memory responder for the CPU data port: accepts one access, stalls
// the pipeline for LATENCY wait cycles, then pulses rdy with the result.
module dm_mem_responder
  import dm_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = DM_DATA_W,
  parameter int LATENCY = DM_DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              rdy,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is re|we seen in IDLE; stall rises combinationally in that
  // same cycle and stays high through WAIT, during which the CPU holds its inputs.
  // rdy is a single-cycle completion pulse in RESP; inputs seen in RESP are ignored.

  localparam logic [DM_CNT_W-1:0] LAT_M1 = DM_CNT_W'(LATENCY - 1);

  dm_state_e             state_q, state_d;
  logic [DM_CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ADDR_W-1:0]     addr_q,  addr_d;
  logic [DATA_W-1:0]     data_q,  data_d;
  logic                  wr_q,    wr_d;
  logic                  rd_q,    rd_d;
  logic                  mem_we;
  logic                  mem_re;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^addr[15:ADDR_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    stall   = 1'b0;
    rdy     = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (re || we) begin
          stall   = 1'b1;
          addr_d  = addr[ADDR_W-1:0];
          data_d  = wrt_data;
          wr_d    = we;
          rd_d    = re;
          cnt_d   = LAT_M1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DM_CNT_W'(1);
        end else begin
          mem_we  = wr_q;
          mem_re  = rd_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rdy     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  dm_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (rd_data)
  );

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dm_mem_responder.sv
// Directed bench for dm_mem_responder: LATENCY=4 instance for the main scenarios,
// LATENCY=1 instance for back-to-back and address aliasing.
module tb_dm_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr0, addr1, wd0, wd1, rd0, rd1;
  logic        re0, we0, re1, we1;
  logic        stall0, stall1, rdy0, rdy1;
  logic [1:0]  st0, st1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dm_mem_responder #(.ADDR_W(10), .DATA_W(16), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr0), .re(re0), .we(we0), .wrt_data(wd0),
    .rd_data(rd0), .stall(stall0), .rdy(rdy0), .dbg_state(st0));

  dm_mem_responder #(.ADDR_W(10), .DATA_W(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr1), .re(re1), .we(we1), .wrt_data(wd1),
    .rd_data(rd1), .stall(stall1), .rdy(rdy1), .dbg_state(st1));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one request from a negedge and observes it until rdy; cycle 0 is the request cycle.
  task automatic run_access(input bit on1, input bit r, input bit w, input logic [15:0] a,
                            input logic [15:0] d, input int mid_cyc, input logic [15:0] mid_a,
                            output int stall_n, output int rdy_at, output bit stall_at_rdy);
    stall_n = 0;
    rdy_at = -1;
    stall_at_rdy = 1'b0;
    if (on1) begin re1 = r; we1 = w; addr1 = a; wd1 = d; end
    else     begin re0 = r; we0 = w; addr0 = a; wd0 = d; end
    for (int c = 0; c < 40; c++) begin
      #1;
      if (on1 ? rdy1 : rdy0) begin
        rdy_at = c;
        stall_at_rdy = on1 ? stall1 : stall0;
        break;
      end
      if (on1 ? stall1 : stall0) stall_n++;
      if (c == mid_cyc) begin
        if (on1) addr1 = mid_a; else addr0 = mid_a;
      end
      step();
    end
    if (on1) begin re1 = 1'b0; we1 = 1'b0; end
    else     begin re0 = 1'b0; we0 = 1'b0; end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    re0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005; wd0 = 16'h0000;
    re1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wd1 = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL reset_stall_comb: got %0b expected 1", stall0); end
    checks++; if (st0 !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d expected 0", st0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %0b expected 0", rdy0); end
    checks++; if (rd0 !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd0); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %0b expected 0", stall1); end
    rst_n = 1'b1;
    step();
    #1;
    checks++; if (st0 !== 2'b01 || stall0 !== 1'b1) begin errors++; $display("FAIL reset_release_wait: got state %0d stall %0b expected 1 1", st0, stall0); end
    for (int c = 0; c < 20; c++) begin
      if (rdy0) break;
      step();
      #1;
    end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_release_rdy: got %0b expected 1", rdy0); end
    re0 = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    int sn, ra;
    bit sr;
    run_access(1'b0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, -1, 16'h0, sn, ra, sr);
    checks++; if (sn !== 5) begin errors++; $display("FAIL write_stall_cycles: got %0d expected 5", sn); end
    checks++; if (ra !== 5) begin errors++; $display("FAIL write_rdy_cycle: got %0d expected 5", ra); end
    checks++; if (sr !== 1'b0) begin errors++; $display("FAIL write_stall_in_resp: got %0b expected 0", sr); end
    run_access(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, -1, 16'h0, sn, ra, sr);
    checks++; if (ra !== 5) begin errors++; $display("FAIL read_rdy_cycle: got %0d expected 5", ra); end
    checks++; if (rd0 !== 16'hBEEF) begin errors++; $display("FAIL read_data: got %0h expected beef", rd0); end
    run_access(1'b0, 1'b0, 1'b1, 16'h0007, 16'h1111, -1, 16'h0, sn, ra, sr);
    checks++; if (rd0 !== 16'hBEEF) begin errors++; $display("FAIL write_keeps_rd_data: got %0h expected beef", rd0); end
  endtask

  task automatic test_fsm_states();
    re0 = 1'b1; addr0 = 16'h0007;
    step();
    #1;
    checks++; if (st0 !== 2'b01) begin errors++; $display("FAIL fsm_wait: got %0d expected 1", st0); end
    for (int c = 0; c < 4; c++) step();
    #1;
    checks++; if (st0 !== 2'b10 || rdy0 !== 1'b1) begin errors++; $display("FAIL fsm_resp: got state %0d rdy %0b expected 2 1", st0, rdy0); end
    checks++; if (rd0 !== 16'h1111) begin errors++; $display("FAIL fsm_read_data: got %0h expected 1111", rd0); end
    re0 = 1'b0;
    step();
    #1;
    checks++; if (st0 !== 2'b00 || rdy0 !== 1'b0) begin errors++; $display("FAIL fsm_idle: got state %0d rdy %0b expected 0 0", st0, rdy0); end
  endtask

  task automatic test_input_change();
    int sn, ra;
    bit sr;
    run_access(1'b0, 1'b0, 1'b1, 16'h0006, 16'h6666, -1, 16'h0, sn, ra, sr);
    run_access(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 2, 16'h0006, sn, ra, sr);
    checks++; if (rd0 !== 16'hBEEF) begin errors++; $display("FAIL mid_wait_addr_change: got %0h expected beef", rd0); end
    checks++; if (ra !== 5) begin errors++; $display("FAIL mid_wait_rdy_cycle: got %0d expected 5", ra); end
  endtask

  task automatic test_read_write_both();
    int sn, ra;
    bit sr;
    run_access(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, -1, 16'h0, sn, ra, sr);
    checks++; if (rd0 !== 16'h1234) begin errors++; $display("FAIL rw_write_through: got %0h expected 1234", rd0); end
    run_access(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, -1, 16'h0, sn, ra, sr);
    run_access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, -1, 16'h0, sn, ra, sr);
    checks++; if (rd0 !== 16'h1234) begin errors++; $display("FAIL rw_stored: got %0h expected 1234", rd0); end
  endtask

  task automatic test_reset_mid_access();
    int sn, ra;
    bit sr;
    run_access(1'b0, 1'b0, 1'b1, 16'h0003, 16'h5555, -1, 16'h0, sn, ra, sr);
    we0 = 1'b1; addr0 = 16'h0003; wd0 = 16'hAAAA;
    step();
    step();
    rst_n = 1'b0;
    we0 = 1'b0;
    #1;
    checks++; if (st0 !== 2'b00) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", st0); end
    checks++; if (rdy0 !== 1'b0 || stall0 !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got rdy %0b stall %0b expected 0 0", rdy0, stall0); end
    checks++; if (rd0 !== 16'h0000) begin errors++; $display("FAIL rst_mid_rd_data: got %0h expected 0", rd0); end
    step();
    rst_n = 1'b1;
    step();
    run_access(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, -1, 16'h0, sn, ra, sr);
    checks++; if (rd0 !== 16'h5555) begin errors++; $display("FAIL rst_mid_write_aborted: got %0h expected 5555", rd0); end
    checks++; if (ra !== 5) begin errors++; $display("FAIL rst_mid_read_rdy: got %0d expected 5", ra); end
  endtask

  task automatic test_back_to_back();
    int sn, ra;
    bit sr;
    logic [6:0] got_stall, got_rdy, exp_stall, exp_rdy;
    run_access(1'b1, 1'b0, 1'b1, 16'h0405, 16'hC0DE, -1, 16'h0, sn, ra, sr);
    checks++; if (sn !== 2 || ra !== 2) begin errors++; $display("FAIL lat1_write_timing: got stall %0d rdy %0d expected 2 2", sn, ra); end
    exp_stall = 7'b0011011;
    exp_rdy   = 7'b0100100;
    got_stall = '0;
    got_rdy   = '0;
    re1 = 1'b1; we1 = 1'b0; addr1 = 16'h0005;
    for (int c = 0; c < 7; c++) begin
      #1;
      got_stall[c] = stall1;
      got_rdy[c]   = rdy1;
      if (c == 5) re1 = 1'b0;
      step();
    end
    checks++; if (got_stall !== exp_stall) begin errors++; $display("FAIL b2b_stall: got %b expected %b", got_stall, exp_stall); end
    checks++; if (got_rdy !== exp_rdy) begin errors++; $display("FAIL b2b_rdy: got %b expected %b", got_rdy, exp_rdy); end
    checks++; if (rd1 !== 16'hC0DE) begin errors++; $display("FAIL alias_data: got %0h expected c0de", rd1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_fsm_states();
    test_input_change();
    test_read_write_both();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
